uart_tx_frac: RTL

Byte-wide UART transmitter, the transmit-side counterpart to the uart_rx block. It serialises one 8N1 frame per accepted byte. Each bit period is `BIT_CNT` clock cycles plus a per-bit fractional correction taken from the 10-bit `BIT_MASK`, which keeps the TX baud rate matched to the receiver's fractional bit timing. It sits between the core's output byte stream and the FPGA TX pin.

---
 rtl/uart_tx_frac.sv | 115 +++++++++++
 1 files changed

// File: rtl/uart_tx_frac.sv
// 8N1 UART transmitter; bit k lasts BIT_CNT + BIT_MASK[k] cycles, tx registered (start bit visible the cycle after accept).
// Backpressure: tx_ready high only in IDLE; tx_valid is ignored for the whole frame, nothing is queued.
module uart_tx_frac #(
    parameter int         WIDTH    = 8,
    parameter int         BIT_CNT  = 168,
    parameter logic [9:0] BIT_MASK = 10'h3df
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Zero-padded so any 4-bit index is in range.
    localparam logic [15:0] MASK_EXT = {6'd0, BIT_MASK};

    state_t           r_state;
    state_t           w_next_state;
    logic [7:0]       r_shreg;
    logic [7:0]       w_next_shreg;
    logic [3:0]       r_idx;
    logic [3:0]       w_next_idx;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_next_cnt;
    logic [WIDTH-1:0] w_term;
    logic             r_tx;
    logic             w_next_tx;
    logic             w_last;
    logic             w_accept;

    assign w_term   = WIDTH'(BIT_CNT) + WIDTH'(MASK_EXT[r_idx]) - WIDTH'(1);
    assign w_last   = (r_cnt == w_term);
    assign tx_ready = (r_state == S_IDLE) && !RESET;
    assign w_accept = tx_valid && tx_ready;
    assign tx_busy  = (r_state != S_IDLE) && !RESET;
    assign tx_done  = (r_state == S_STOP) && w_last && !RESET;
    assign tx       = r_tx;

    always_comb begin
        w_next_state = r_state;
        w_next_shreg = r_shreg;
        w_next_idx   = r_idx;
        w_next_cnt   = r_cnt + WIDTH'(1);
        case (r_state)
            S_IDLE: begin
                w_next_cnt = '0;
                if (w_accept) begin
                    w_next_state = S_START;
                    w_next_shreg = tx_data;
                    w_next_idx   = 4'd0;
                end
            end
            S_START: begin
                if (w_last) begin
                    w_next_cnt   = '0;
                    w_next_idx   = r_idx + 4'd1;
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (w_last) begin
                    w_next_cnt   = '0;
                    w_next_idx   = r_idx + 4'd1;
                    w_next_shreg = {1'b0, r_shreg[7:1]};
                    if (r_idx == 4'd8) begin
                        w_next_state = S_STOP;
                    end
                end
            end
            default: begin
                if (w_last) begin
                    w_next_cnt   = '0;
                    w_next_idx   = 4'd0;
                    w_next_state = S_IDLE;
                end
            end
        endcase

        // Line level follows the state being entered so tx changes on the same edge.
        w_next_tx = 1'b1;
        case (w_next_state)
            S_START: w_next_tx = 1'b0;
            S_DATA:  w_next_tx = w_next_shreg[0];
            default: w_next_tx = 1'b1;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_shreg <= w_next_shreg;
            r_idx   <= w_next_idx;
            r_cnt   <= w_next_cnt;
            r_tx    <= w_next_tx;
        end
    end

endmodule
